// File: rtl/es_multi.sv
// Port-mapped I/O controller: synchronised input ports with sticky change flags,
// output registers with one-cycle write strobes, and a masked priority interrupt.

module es_multi_lane #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] s,
  output logic              diff
);
  logic [SYNC_STAGES-1:0][DATA_W-1:0] chain;
  logic [DATA_W-1:0]                  prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= '0;
      prev  <= '0;
    end else begin
      chain[0] <= din;
      for (int k = 1; k < SYNC_STAGES; k++) chain[k] <= chain[k-1];
      prev <= chain[SYNC_STAGES-1];
    end
  end

  assign s    = chain[SYNC_STAGES-1];
  assign diff = (s != prev);
endmodule

module es_multi #(
  parameter int DATA_W      = 8,
  parameter int NIN         = 4,
  parameter int NOUT        = 4,
  parameter int ID_W        = 3,
  parameter int SYNC_STAGES = 2,
  parameter int OUT_RST     = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [ID_W-1:0]        port_id,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  input  logic [NIN*DATA_W-1:0]  in_bus,
  output logic [NOUT*DATA_W-1:0] out_bus,
  output logic [NOUT-1:0]        out_stb,
  output logic                   irq,
  output logic [ID_W-1:0]        irq_id
);
  localparam logic [ID_W-1:0]   STATUS    = '1;
  localparam int                WARM      = SYNC_STAGES + 1;
  localparam int                CW        = $clog2(WARM + 1);
  localparam logic [CW-1:0]     WARM_C    = CW'(WARM);
  localparam logic [DATA_W-1:0] OUT_RST_V = DATA_W'(OUT_RST);

  logic [NIN-1:0][DATA_W-1:0]  s;
  logic [NIN-1:0]              diff, chg, chg_nxt, mask, pend, rd_hit;
  logic [NOUT-1:0]             wr_hit;
  logic [NOUT-1:0][DATA_W-1:0] out_q;
  logic [DATA_W-1:0]           rd_val;
  logic [ID_W-1:0]             id_nxt;
  logic [CW-1:0]               cnt;
  logic                        warm;

  for (genvar i = 0; i < NIN; i++) begin : g_lane
    es_multi_lane #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) u_lane (
      .clk  (clk),
      .reset(reset),
      .din  (in_bus[i*DATA_W +: DATA_W]),
      .s    (s[i]),
      .diff (diff[i])
    );
  end

  // Flags stay blocked until the sync chains and prev have flushed the reset zeros.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     cnt <= '0;
    else if (!warm) cnt <= cnt + 1'b1;
  end
  assign warm = (cnt == WARM_C);

  always_comb begin
    rd_hit = '0;
    wr_hit = '0;
    rd_val = '0;
    for (int i = 0; i < NIN; i++)
      if (port_id == ID_W'(i)) begin
        rd_hit[i] = rd_en;
        rd_val    = s[i];
      end
    if (port_id == STATUS) rd_val = DATA_W'(chg);
    for (int i = 0; i < NOUT; i++) wr_hit[i] = wr_en && (port_id == ID_W'(i));
    // Set after clear so a new change wins over a same-edge read.
    chg_nxt = (chg & ~rd_hit) | (diff & {NIN{warm}});
    pend    = chg & mask;
    id_nxt  = '0;
    for (int i = NIN - 1; i >= 0; i--)
      if (pend[i]) id_nxt = ID_W'(i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chg     <= '0;
      mask    <= '0;
      rdata   <= '0;
      out_stb <= '0;
      irq     <= 1'b0;
      irq_id  <= '0;
      out_q   <= {NOUT{OUT_RST_V}};
    end else begin
      chg     <= chg_nxt;
      out_stb <= wr_hit;
      irq     <= |pend;
      irq_id  <= id_nxt;
      if (rd_en) rdata <= rd_val;
      if (wr_en && port_id == STATUS) mask <= wdata[NIN-1:0];
      for (int i = 0; i < NOUT; i++)
        if (wr_hit[i]) out_q[i] <= wdata;
    end
  end

  assign out_bus = out_q;
endmodule

// File: tb/tb_es_multi.sv
// Directed scenarios plus random traffic against a cycle-level reference of es_multi.
module tb_es_multi;
  localparam int DATA_W = 8, NIN = 4, NOUT = 4, ID_W = 3, S = 2;
  localparam logic [2:0] ST = 3'd7;

  logic        clk = 1'b0, reset = 1'b0, rd_en = 1'b0, wr_en = 1'b0;
  logic [2:0]  port_id = '0;
  logic [7:0]  wdata = '0, rdata;
  logic [31:0] in_bus = '0, out_bus;
  logic [3:0]  out_stb;
  logic        irq;
  logic [2:0]  irq_id;

  es_multi #(.DATA_W(DATA_W), .NIN(NIN), .NOUT(NOUT), .ID_W(ID_W),
             .SYNC_STAGES(S), .OUT_RST(0)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .wr_en(wr_en), .port_id(port_id),
    .wdata(wdata), .rdata(rdata), .in_bus(in_bus), .out_bus(out_bus),
    .out_stb(out_stb), .irq(irq), .irq_id(irq_id));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // Reference state: hist[j] is the in_bus value present before edge j since release.
  logic [31:0] hist [0:1023];
  int          n;
  logic [3:0]  m_chg, m_mask, m_stb;
  logic [31:0] m_out, cur_in;
  logic [7:0]  m_rdata;
  logic        m_irq;
  logic [2:0]  m_id;

  function automatic logic [31:0] s_after(input int k);
    if (k < S) return '0;
    return hist[k-S+1];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_chg = '0; m_mask = '0; m_stb = '0; m_out = '0; m_rdata = '0;
    m_irq = 1'b0; m_id = '0; n = 0;
  endtask

  task automatic step(input string tag, input logic rd, input logic wr,
                      input logic [2:0] id, input logic [7:0] wd, input logic [31:0] inb);
    logic [31:0] sn, sa, sb;
    logic [3:0]  pend, clr, set;
    int          n1;
    rd_en = rd; wr_en = wr; port_id = id; wdata = wd; in_bus = inb;
    n1 = n + 1;
    hist[n1] = inb;
    sn = s_after(n); sa = s_after(n1 - 1); sb = s_after(n1 - 2);
    pend = m_chg & m_mask;
    clr = '0; set = '0;
    if (rd) begin
      if (id < NIN) begin m_rdata = sn[id*8 +: 8]; clr[id] = 1'b1; end
      else if (id == ST) m_rdata = {4'b0, m_chg};
      else m_rdata = '0;
    end
    for (int i = 0; i < NIN; i++)
      if (n1 >= S + 2 && sa[i*8 +: 8] != sb[i*8 +: 8]) set[i] = 1'b1;
    m_chg = (m_chg & ~clr) | set;
    m_stb = '0;
    if (wr && id < NOUT) begin m_out[id*8 +: 8] = wd; m_stb[id] = 1'b1; end
    else if (wr && id == ST) m_mask = wd[3:0];
    m_irq = |pend;
    m_id = '0;
    for (int i = NIN - 1; i >= 0; i--) if (pend[i]) m_id = 3'(i);
    n = n1;
    @(posedge clk); #1;
    chk({tag, "_rdata"}, 64'(rdata), 64'(m_rdata));
    chk({tag, "_out_bus"}, 64'(out_bus), 64'(m_out));
    chk({tag, "_out_stb"}, 64'(out_stb), 64'(m_stb));
    chk({tag, "_irq"}, 64'(irq), 64'(m_irq));
    chk({tag, "_irq_id"}, 64'(irq_id), 64'(m_id));
  endtask

  task automatic idle(input string tag);          step(tag, 0, 0, 3'd0, 8'h00, cur_in); endtask
  task automatic rd(input string tag, input logic [2:0] id); step(tag, 1, 0, id, 8'h00, cur_in); endtask
  task automatic wr(input string tag, input logic [2:0] id, input logic [7:0] d); step(tag, 0, 1, id, d, cur_in); endtask

  initial begin
    // 1: static levels through reset never flag
    cur_in = 32'hA5A5_A5A5;
    in_bus = cur_in;
    model_reset();
    #1;
    chk("rst_rdata", 64'(rdata), 64'h0);
    chk("rst_out_bus", 64'(out_bus), 64'h0);
    chk("rst_stb_irq", 64'({out_stb, irq, irq_id}), 64'h0);
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 10; i++) idle("t1");
    chk("t1_irq", 64'(irq), 64'h0);
    rd("t1_status", ST);
    chk("t1_chg", 64'(rdata), 64'h0);

    // 2: valid write strobes, out-of-range write ignored
    wr("t2_w2", 3'd2, 8'h3C);
    chk("t2_stb", 64'(out_stb), 64'h4);
    chk("t2_out", 64'(out_bus), 64'h003C_0000);
    wr("t2_w5", 3'd5, 8'hFF);
    chk("t2_stb5", 64'(out_stb), 64'h0);
    wr("t2_b2b_a", 3'd1, 8'h11);
    wr("t2_b2b_b", 3'd1, 8'h22);
    chk("t2_b2b", 64'(out_stb), 64'h2);

    // 3: single port change, status read, clearing read
    cur_in = 32'h0;
    for (int i = 0; i < 5; i++) idle("t3_settle");
    for (int i = 0; i < 4; i++) rd("t3_clr", 3'(i));
    cur_in[15:8] = 8'h7F;
    for (int i = 0; i < 3; i++) idle("t3_wait");
    rd("t3_status", ST);
    chk("t3_status_val", 64'(rdata), 64'h02);
    rd("t3_port1", 3'd1);
    chk("t3_port1_val", 64'(rdata), 64'h7F);
    rd("t3_status2", ST);
    chk("t3_cleared", 64'(rdata), 64'h00);
    rd("t3_bad_port", 3'd5);

    // 4: masked priority interrupt
    wr("t4_mask", ST, 8'h0A);
    cur_in[31:24] = 8'h12;
    cur_in[15:8]  = 8'h34;
    for (int i = 0; i < 4; i++) idle("t4_wait");
    chk("t4_irq", 64'({irq, irq_id}), 64'({1'b1, 3'd1}));
    rd("t4_rd1", 3'd1);
    idle("t4_after1");
    chk("t4_id3", 64'({irq, irq_id}), 64'({1'b1, 3'd3}));
    rd("t4_rd3", 3'd3);
    idle("t4_after3");
    chk("t4_irq0", 64'(irq), 64'h0);

    // 5: clear and set of the same flag on one edge
    cur_in[7:0] = 8'h99;
    idle("t5_a");
    idle("t5_b");
    rd("t5_rd0", 3'd0);
    rd("t5_status", ST);
    chk("t5_set_wins", 64'(rdata[0]), 64'h1);

    // 6: reset during a strobe, then warm-up
    wr("t6_mask", ST, 8'h0F);
    rd("t6_rd1", 3'd1);
    wr("t6_w0", 3'd0, 8'h55);
    #2 reset = 1'b0;
    cur_in = 32'hC3C3_C3C3;
    in_bus = cur_in;
    #1;
    chk("t6_out_clr", 64'(out_bus), 64'h0);
    chk("t6_stb_clr", 64'(out_stb), 64'h0);
    chk("t6_rdata_clr", 64'(rdata), 64'h0);
    model_reset();
    @(posedge clk); #1 reset = 1'b1;
    cur_in[23:16] = 8'h11;
    for (int i = 0; i < 6; i++) idle("t6_warm");
    rd("t6_status", ST);
    chk("t6_noflag", 64'(rdata), 64'h0);

    // random traffic
    wr("rnd_mask", ST, 8'(($urandom_range(0, 15))));
    for (int t = 0; t < 300; t++) begin
      logic r, w;
      r = ($urandom_range(0, 2) == 0);
      w = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < NIN; i++)
        if ($urandom_range(0, 5) == 0) cur_in[i*8 +: 8] = 8'($urandom);
      step("rnd", r, w, 3'($urandom_range(0, 7)), 8'($urandom), cur_in);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
